// File: rtl/synth_seq_pkg.sv
// synth_seq_pkg: shared state encoding, step-slot record and timing constants for gate_sequencer
package synth_seq_pkg;
  localparam int SEQ_LEN_MAX = 24;
  localparam int SEQ_MIN_LOW = 1;
  typedef enum logic [1:0] {IDLE, GATE_ON, GATE_OFF, WAIT_REL} seq_state_t;
  typedef struct packed {
    logic rest;
    logic [SEQ_LEN_MAX-1:0] length;
    logic [SEQ_LEN_MAX-1:0] period;
  } seq_step_t;
endpackage

// File: rtl/gate_sequencer_if.sv
// gate_sequencer_if: control, step-write and envelope handshake signals of gate_sequencer
interface gate_sequencer_if #(parameter int STEPS = 8, parameter int LEN_W = 24) ();
  localparam int SW = $clog2(STEPS);
  logic Start, Stop, Loop, WrEn, WrRest, Running;
  logic [SW-1:0] WrAddr;
  logic [LEN_W-1:0] WrLength, WrPeriod;
  logic Gate, Active, Done;
  logic [SW-1:0] Step;
  modport master (output Start, Stop, Loop, WrEn, WrAddr, WrLength, WrPeriod, WrRest, Running,
                  input Gate, Step, Active, Done);
  modport slave (input Start, Stop, Loop, WrEn, WrAddr, WrLength, WrPeriod, WrRest, Running,
                 output Gate, Step, Active, Done);
endinterface

// File: rtl/gate_seq_step_ram.sv
// gate_seq_step_ram: step-slot registers, one sync write port, one combinational read port
module gate_seq_step_ram import synth_seq_pkg::*; #(
  parameter int STEPS = 8,
  localparam int SW = $clog2(STEPS)
) (
  input  logic clk,
  input  logic rst,
  input  logic wr_en,
  input  logic [SW-1:0] wr_addr,
  input  seq_step_t wr_data,
  input  logic [SW-1:0] rd_addr,
  output seq_step_t rd_data
);
  seq_step_t mem [STEPS];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) mem[i] <= '{rest: 1'b1, length: '0, period: SEQ_LEN_MAX'(1)};
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end
  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/gate_sequencer.sv
// gate_sequencer: step sequencer driving envelope Gate; GATE_SEQ_WAIT_RELEASE_EN adds WAIT_REL on Running
module gate_sequencer import synth_seq_pkg::*; #(
  parameter int STEPS = 8,
  parameter int LEN_W = 24
) (
  input logic Clock,
  input logic Reset,
  gate_sequencer_if.slave bus
);
  localparam int SW = $clog2(STEPS);
  seq_state_t state, state_n;
  logic [LEN_W-1:0] cnt, cnt_n, low, low_n, len, per, len1, per1, low_ld;
  logic [LEN_W:0] diff;
  logic [SW-1:0] step, step_n, nstep, rd_addr;
  logic gate, gate_n, active, active_n, done, done_n, load, last;
  seq_step_t rd, wr;
  assign wr = '{rest: bus.WrRest, length: SEQ_LEN_MAX'(bus.WrLength), period: SEQ_LEN_MAX'(bus.WrPeriod)};
  gate_seq_step_ram #(.STEPS(STEPS)) ram (
    .clk(Clock), .rst(Reset), .wr_en(bus.WrEn), .wr_addr(bus.WrAddr), .wr_data(wr),
    .rd_addr(rd_addr), .rd_data(rd)
  );
  assign nstep = step + 1'b1;
  assign last = step == SW'(STEPS - 1);
  assign rd_addr = state == IDLE ? '0 : state == GATE_OFF ? nstep : step;
  assign len = rd.length[LEN_W-1:0];
  assign per = rd.period[LEN_W-1:0];
  assign len1 = len == '0 ? LEN_W'(1) : len;
  assign per1 = per == '0 ? LEN_W'(1) : per;
  // low phase is evaluated with a sign bit so P<=L still leaves one low cycle
  assign diff = {1'b0, per} - {1'b0, len};
  assign low_ld = (diff[LEN_W] || diff == '0) ? LEN_W'(SEQ_MIN_LOW) : diff[LEN_W-1:0];
`ifndef GATE_SEQ_WAIT_RELEASE_EN
  logic unused_running;
  assign unused_running = bus.Running;
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    low_n = low;
    step_n = step;
    gate_n = gate;
    active_n = active;
    done_n = 1'b0;
    load = 1'b0;
    if (bus.Stop) begin
      state_n = IDLE;
      gate_n = 1'b0;
      active_n = 1'b0;
      step_n = '0;
    end else begin
      case (state)
        IDLE: load = bus.Start;
        GATE_ON: begin
          cnt_n = cnt == LEN_W'(1) ? low : cnt - 1'b1;
          state_n = cnt == LEN_W'(1) ? GATE_OFF : GATE_ON;
          gate_n = cnt != LEN_W'(1);
        end
        GATE_OFF: begin
          if (cnt != LEN_W'(1)) cnt_n = cnt - 1'b1;
          else if (last && !bus.Loop) begin
            state_n = IDLE;
            active_n = 1'b0;
            done_n = 1'b1;
            step_n = '0;
          end else begin
            step_n = nstep;
`ifdef GATE_SEQ_WAIT_RELEASE_EN
            state_n = (!rd.rest && bus.Running) ? WAIT_REL : GATE_OFF;
            load = rd.rest || !bus.Running;
`else
            load = 1'b1;
`endif
          end
        end
`ifdef GATE_SEQ_WAIT_RELEASE_EN
        WAIT_REL: load = !bus.Running;
`endif
        default: state_n = IDLE;
      endcase
    end
    if (load) begin
      state_n = rd.rest ? GATE_OFF : GATE_ON;
      gate_n = !rd.rest;
      cnt_n = rd.rest ? per1 : len1;
      low_n = low_ld;
      active_n = 1'b1;
    end
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      cnt <= '0;
      low <= '0;
      step <= '0;
      gate <= 1'b0;
      active <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      low <= low_n;
      step <= step_n;
      gate <= gate_n;
      active <= active_n;
      done <= done_n;
    end
  end
  assign bus.Gate = gate;
  assign bus.Step = step;
  assign bus.Active = active;
  assign bus.Done = done;
endmodule

// File: tb/tb_gate_sequencer.sv
// tb_gate_sequencer: event scoreboard (gate edges, Done) plus level checks for gate_sequencer
module tb_gate_sequencer;
  localparam int STEPS = 4;
  localparam int LEN_W = 24;
  localparam int RISE = 0, FALL = 1, DONE = 2;
  typedef struct {int kind; int cyc;} ev_t;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, checks = 0, failures = 0, t = 0;
  logic gate_prev = 1'b0;
  ev_t expq[$];
  gate_sequencer_if #(.STEPS(STEPS), .LEN_W(LEN_W)) bus ();
  gate_sequencer #(.STEPS(STEPS), .LEN_W(LEN_W)) dut (.Clock(clk), .Reset(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic push(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc = c;
    expq.push_back(e);
  endtask
  task automatic observe(input int kind);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      failures++;
      $display("FAIL event: got kind=%0d at cycle %0d, required no event", kind, cyc);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        failures++;
        $display("FAIL event: got kind=%0d cycle=%0d, required kind=%0d cycle=%0d", kind, cyc, e.kind, e.cyc);
      end
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.Gate && !gate_prev) observe(RISE);
      if (!bus.Gate && gate_prev) observe(FALL);
      if (bus.Done) observe(DONE);
    end
    gate_prev <= bus.Gate;
  end
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  task automatic write_slot(input int a, input int l, input int p, input bit r);
    bus.WrEn = 1'b1;
    bus.WrAddr = 2'(a);
    bus.WrLength = LEN_W'(l);
    bus.WrPeriod = LEN_W'(p);
    bus.WrRest = r;
    @(negedge clk);
    bus.WrEn = 1'b0;
  endtask
  task automatic start_seq();
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
  endtask
  initial begin
    bus.Start = 0; bus.Stop = 0; bus.Loop = 0; bus.WrEn = 0; bus.WrAddr = '0;
    bus.WrLength = '0; bus.WrPeriod = '0; bus.WrRest = 0; bus.Running = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_gate", int'(bus.Gate), 0);
    check("reset_step", int'(bus.Step), 0);
    check("reset_active", int'(bus.Active), 0);
    check("reset_done", int'(bus.Done), 0);
    // default slots: STEPS rest steps of one cycle
    t = cyc;
    push(DONE, t + 5);
    start_seq();
    check("default_active", int'(bus.Active), 1);
    check("default_gate", int'(bus.Gate), 0);
    wait_until(t + 8);
    check("default_idle", int'(bus.Active), 0);
    // all slots L=3 P=5
    for (int i = 0; i < STEPS; i++) write_slot(i, 3, 5, 0);
    t = cyc;
    for (int k = 0; k < 4; k++) begin
      push(RISE, t + 1 + 5 * k);
      push(FALL, t + 4 + 5 * k);
    end
    push(DONE, t + 21);
    start_seq();
    wait_until(t + 7);
    check("l3p5_step", int'(bus.Step), 1);
    wait_until(t + 24);
    // slot 1 with P<L
    write_slot(1, 6, 4, 0);
    t = cyc;
    push(RISE, t + 1); push(FALL, t + 4); push(RISE, t + 6); push(FALL, t + 12);
    push(RISE, t + 13); push(FALL, t + 16); push(RISE, t + 18); push(FALL, t + 21);
    push(DONE, t + 23);
    start_seq();
    wait_until(t + 26);
    // looping, then Stop during GATE_ON
    for (int i = 0; i < STEPS; i++) write_slot(i, 2, 3, 0);
    bus.Loop = 1'b1;
    t = cyc;
    for (int k = 0; k < 4; k++) begin
      push(RISE, t + 1 + 3 * k);
      push(FALL, t + 3 + 3 * k);
    end
    push(RISE, t + 13);
    push(FALL, t + 14);
    start_seq();
    wait_until(t + 13);
    bus.Stop = 1'b1;
    @(negedge clk);
    bus.Stop = 1'b0;
    check("stop_active", int'(bus.Active), 0);
    check("stop_step", int'(bus.Step), 0);
    check("stop_gate", int'(bus.Gate), 0);
    bus.Loop = 1'b0;
    repeat (5) @(negedge clk);
    // Start and Stop together
    bus.Start = 1'b1;
    bus.Stop = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    bus.Stop = 1'b0;
    check("startstop_active", int'(bus.Active), 0);
    repeat (3) @(negedge clk);
    check("startstop_active_later", int'(bus.Active), 0);
    // write slot 0 on its loading edge, slot 2 while step 1 plays
    t = cyc;
    push(RISE, t + 1); push(FALL, t + 3); push(RISE, t + 4); push(FALL, t + 6);
    push(RISE, t + 7); push(FALL, t + 8); push(RISE, t + 9); push(FALL, t + 11);
    push(DONE, t + 12);
    bus.Start = 1'b1;
    write_slot(0, 5, 6, 0);
    bus.Start = 1'b0;
    wait_until(t + 5);
    write_slot(2, 1, 2, 0);
    wait_until(t + 14);
    t = cyc;
    push(RISE, t + 1); push(FALL, t + 6); push(RISE, t + 7); push(FALL, t + 9);
    push(RISE, t + 10); push(FALL, t + 11); push(RISE, t + 12); push(FALL, t + 14);
    push(DONE, t + 15);
    start_seq();
    wait_until(t + 17);
`ifdef GATE_SEQ_WAIT_RELEASE_EN
    write_slot(0, 2, 3, 0);
    bus.Running = 1'b1;
    t = cyc;
    push(RISE, t + 1); push(FALL, t + 3); push(RISE, t + 14); push(FALL, t + 16);
    push(RISE, t + 17); push(FALL, t + 18); push(RISE, t + 19); push(FALL, t + 21);
    push(DONE, t + 22);
    start_seq();
    wait_until(t + 8);
    check("waitrel_step", int'(bus.Step), 1);
    check("waitrel_gate", int'(bus.Gate), 0);
    check("waitrel_active", int'(bus.Active), 1);
    wait_until(t + 13);
    bus.Running = 1'b0;
    wait_until(t + 25);
`endif
    check("events_pending", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
